population_sequencer: RTL and testbench

// - Top-level phase scheduler for one GA population: owns networkState and activeNetwork.
// - Per generation it steps through: evaluate every network -> sort by fitness -> breed.
// - Feeds each network's fitness to the sort block.
// - Guarantees exactly one block drives the shared RAM bus at a time.
// - Inserts one bus-turnaround cycle (networkState=0) between owners.

---
 rtl/population_sequencer_pkg.sv | 34 +++
 rtl/population_sequencer_eval_watchdog.sv | 37 +++
 rtl/population_sequencer.sv | 154 +++++++++++++++
 tb/tb_population_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/population_sequencer_pkg.sv
// Shared GA definitions: bus-owner codes, data widths and the sequencer state set.
// The evaluator, sort and breeder blocks import the same codes.
package population_sequencer_pkg;

    localparam int FIT_W = 16;
    localparam int GEN_W = 16;

    localparam logic [1:0] NS_IDLE  = 2'd0;
    localparam logic [1:0] NS_EVAL  = 2'd1;
    localparam logic [1:0] NS_SORT  = 2'd2;
    localparam logic [1:0] NS_BREED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EVAL      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SORT_GAP  = 3'd3,
        ST_SORT      = 3'd4,
        ST_BREED_GAP = 3'd5,
        ST_BREED     = 3'd6,
        ST_GEN_END   = 3'd7
    } seq_state_e;

    // Bus owner for a sequencer state; every gap/load state releases the bus.
    function automatic logic [1:0] ns_code(input seq_state_e s);
        case (s)
            ST_EVAL:  ns_code = NS_EVAL;
            ST_SORT:  ns_code = NS_SORT;
            ST_BREED: ns_code = NS_BREED;
            default:  ns_code = NS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/population_sequencer_eval_watchdog.sv
// Per-network evaluation timer: restarts on each EVAL entry and flags the last
// allowed cycle. EVAL_TIMEOUT of 0 disables the flag entirely.
module population_sequencer_eval_watchdog #(
    parameter int EVAL_TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic timeout_o
);

    localparam int TW = (EVAL_TIMEOUT > 1) ? $clog2(EVAL_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = (EVAL_TIMEOUT > 0) ? TW'(EVAL_TIMEOUT - 1) : '0;
    localparam bit ENABLED = (EVAL_TIMEOUT != 0);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Holding the timer at zero outside EVAL gives a fresh count on every entry.
    always_comb begin
        timer_d = '0;
        if (run_i) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout_o = ENABLED && run_i && (timer_q == LAST);

endmodule

// File: rtl/population_sequencer.sv
// Generation scheduler for one GA population: evaluate each network, sort, breed,
// with a bus-turnaround cycle (networkState 0) between every pair of bus owners.
module population_sequencer
    import population_sequencer_pkg::*;
#(
    parameter int NETWORKS_PER_POPULATION = 16,
    parameter int NET_W                   = 4,
    parameter int EVAL_TIMEOUT            = 4095,
    parameter int MAX_GENERATIONS         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_req_i,
    input  logic             eval_done_i,
    input  logic [FIT_W-1:0] eval_fitness_i,
    input  logic             sort_finished_i,
    input  logic             breed_finished_i,
    output logic [1:0]       network_state_o,
    output logic [NET_W-1:0] active_network_o,
    output logic [FIT_W-1:0] fitness_o,
    output logic [GEN_W-1:0] generation_o,
    output logic [FIT_W-1:0] best_fitness_o,
    output logic             timeout_seen_o,
    output logic             busy_o
);

    localparam logic [NET_W-1:0] LAST_NET = NET_W'(NETWORKS_PER_POPULATION - 1);
    localparam logic [GEN_W-1:0] GEN_LIMIT = GEN_W'(MAX_GENERATIONS);
    localparam bit GEN_LIMITED = (MAX_GENERATIONS != 0);

    seq_state_e       state_q, state_d;
    logic [NET_W-1:0] active_q, active_d;
    logic [FIT_W-1:0] fitness_q, fitness_d;
    logic [GEN_W-1:0] generation_q, generation_d;
    logic [FIT_W-1:0] best_q, best_d;
    logic             timeout_seen_q, timeout_seen_d;
    logic [1:0]       ns_q;
    logic             busy_q;
    logic             eval_timeout;

    population_sequencer_eval_watchdog #(
        .EVAL_TIMEOUT(EVAL_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .run_i     (state_q == ST_EVAL),
        .timeout_o (eval_timeout)
    );

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        fitness_d      = fitness_q;
        generation_d   = generation_q;
        best_d         = best_q;
        timeout_seen_d = timeout_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    generation_d   = '0;
                    best_d         = '0;
                    timeout_seen_d = 1'b0;
                    active_d       = '0;
                    state_d        = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // A result arriving on the timeout cycle is still honoured.
                if (eval_done_i) begin
                    fitness_d = eval_fitness_i;
                    if (eval_fitness_i > best_q) begin
                        best_d = eval_fitness_i;
                    end
                    state_d = ST_LOAD;
                end else if (eval_timeout) begin
                    fitness_d      = '0;
                    timeout_seen_d = 1'b1;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (active_q == LAST_NET) begin
                    state_d = ST_SORT_GAP;
                end else begin
                    active_d = active_q + NET_W'(1);
                    state_d  = ST_EVAL;
                end
            end
            ST_SORT_GAP: begin
                state_d = ST_SORT;
            end
            ST_SORT: begin
                if (sort_finished_i) begin
                    state_d = ST_BREED_GAP;
                end
            end
            ST_BREED_GAP: begin
                state_d = ST_BREED;
            end
            ST_BREED: begin
                if (breed_finished_i) begin
                    state_d = ST_GEN_END;
                end
            end
            ST_GEN_END: begin
                generation_d = generation_q + GEN_W'(1);
                best_d       = '0;
                active_d     = '0;
                if (stop_req_i || (GEN_LIMITED && (generation_d == GEN_LIMIT))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus code and busy are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            active_q       <= '0;
            fitness_q      <= '0;
            generation_q   <= '0;
            best_q         <= '0;
            timeout_seen_q <= 1'b0;
            ns_q           <= NS_IDLE;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            fitness_q      <= fitness_d;
            generation_q   <= generation_d;
            best_q         <= best_d;
            timeout_seen_q <= timeout_seen_d;
            ns_q           <= ns_code(state_d);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign network_state_o  = ns_q;
    assign active_network_o = active_q;
    assign fitness_o        = fitness_q;
    assign generation_o     = generation_q;
    assign best_fitness_o   = best_q;
    assign timeout_seen_o   = timeout_seen_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_population_sequencer.sv
// Bench for population_sequencer: a per-cycle expected trace is built from the
// phase rules up front, then replayed against the DUT cycle by cycle.
module tb_population_sequencer;

    localparam int N    = 16;
    localparam int TO   = 8;
    localparam int MAXG = 3;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_req_i = 1'b0;
    logic        eval_done_i = 1'b0;
    logic [15:0] eval_fitness_i = '0;
    logic        sort_finished_i = 1'b0;
    logic        breed_finished_i = 1'b0;
    logic [1:0]  network_state_o;
    logic [3:0]  active_network_o;
    logic [15:0] fitness_o;
    logic [15:0] generation_o;
    logic [15:0] best_fitness_o;
    logic        timeout_seen_o;
    logic        busy_o;

    always #5 clk = ~clk;

    population_sequencer #(
        .NETWORKS_PER_POPULATION(N),
        .NET_W(4),
        .EVAL_TIMEOUT(TO),
        .MAX_GENERATIONS(MAXG)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .stop_req_i       (stop_req_i),
        .eval_done_i      (eval_done_i),
        .eval_fitness_i   (eval_fitness_i),
        .sort_finished_i  (sort_finished_i),
        .breed_finished_i (breed_finished_i),
        .network_state_o  (network_state_o),
        .active_network_o (active_network_o),
        .fitness_o        (fitness_o),
        .generation_o     (generation_o),
        .best_fitness_o   (best_fitness_o),
        .timeout_seen_o   (timeout_seen_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        bit rst, start, stop, done;
        int ef;
        bit sortf, breedf;
        int ns, an, fit, gen, best, to, busy;
    } cyc_t;

    cyc_t sched[$];
    int m_an, m_fit, m_gen, m_best, m_to;
    int n_checks = 0;
    int n_fail = 0;
    int g1, e2, e5, ia, ib, rc, gd;
    int act_ns[MAXC], act_an[MAXC], act_fit[MAXC], act_gen[MAXC];
    int act_best[MAXC], act_to[MAXC], act_busy[MAXC];

    task automatic chk(input string nm, input int cyc, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // One trace cycle: inputs driven during it, outputs the DUT must show during it.
    task automatic push(input int ns, input int busy, input bit r, input bit st, input bit sp,
                        input bit dn, input int ef, input bit sf, input bit bf);
        cyc_t c;
        c.rst = r; c.start = st; c.stop = sp; c.done = dn; c.ef = ef;
        c.sortf = sf; c.breedf = bf;
        c.ns = ns; c.an = m_an; c.fit = m_fit; c.gen = m_gen;
        c.best = m_best; c.to = m_to; c.busy = busy;
        sched.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        m_an = 0; m_fit = 0; m_gen = 0; m_best = 0; m_to = 0;
        push(0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_start();
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        m_gen = 0; m_best = 0; m_to = 0; m_an = 0;
    endtask

    // lat < 0 means the evaluator never answers; st_first pulses start on the
    // first EVAL cycle, dn_load pulses evalDone (with junk data) during LOAD.
    task automatic eval_net(input int lat, input int fv, input bit st_first, input bit dn_load);
        for (int k = 0; k < TO; k++) begin
            bit s;
            s = st_first && (k == 0);
            if (k == lat) begin
                push(1, 1, 0, s, 0, 1, fv, 0, 0);
                m_fit = fv;
                if (fv > m_best) m_best = fv;
                break;
            end else if (k == TO - 1) begin
                push(1, 1, 0, s, 0, 0, fv, 0, 0);
                m_fit = 0;
                m_to = 1;
                break;
            end else begin
                push(1, 1, 0, s, 0, 0, fv, 0, 0);
            end
        end
        push(0, 1, 0, 0, 0, dn_load, 65535, 0, 0);
    endtask

    task automatic eval_all(input int mode);
        for (int i = 0; i < N; i++) begin
            int lat, fv;
            bit sf;
            lat = (mode == 2) ? 0 : 3;
            fv  = (mode == 2) ? ((i * 37) % 101) : (10 * i + ((mode == 1) ? 7 : 0));
            sf  = (mode == 1) && (i == 0);
            if (mode == 1 && i == 2) begin lat = TO - 1; e2 = sched.size(); end
            if (mode == 1 && i == 5) begin lat = -1; e5 = sched.size(); end
            eval_net(lat, fv, sf, sf);
            if (i < N - 1) m_an++;
        end
    endtask

    task automatic sort_breed(input int sl, input int bl, input bit stop);
        push(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= sl; k++) push(2, 1, 0, 0, 0, 0, 0, k == sl, 0);
        push(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= bl; k++) push(3, 1, 0, 0, stop, 0, 0, 0, k == bl);
        push(0, 1, 0, 0, stop, 0, 0, 0, 0);
        m_gen  = (m_gen + 1) & 16'hFFFF;
        m_best = 0;
        m_an   = 0;
    endtask

    task automatic gen_full(input int mode, input bit stop);
        eval_all(mode);
        sort_breed((mode == 2) ? 0 : 5, (mode == 2) ? 0 : 5, stop);
    endtask

    initial begin
        int prev_ns;
        int bad_turn;

        // Run A: three generations, ended by the generation limit.
        do_reset();
        idle(2);
        do_start();
        g1 = sched.size();
        gen_full(0, 0);
        gen_full(1, 0);
        gen_full(0, 0);
        ia = sched.size();
        idle(3);
        // Run B: stop request held through BREED.
        do_start();
        gen_full(0, 1);
        ib = sched.size();
        idle(2);
        // Run C: reset lands in the middle of SORT.
        do_start();
        eval_all(0);
        push(0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(2, 1, 0, 0, 0, 0, 0, 0, 0);
        push(2, 1, 0, 0, 0, 0, 0, 0, 0);
        rc = sched.size();
        do_reset();
        idle(2);
        // Run D: fresh start, shortest possible generations.
        do_start();
        gd = sched.size();
        gen_full(2, 0);
        gen_full(2, 1);
        idle(2);

        if (sched.size() > MAXC) begin
            $display("FAIL trace_length cycle 0: got %0d expected at most %0d", sched.size(), MAXC);
            $fatal(1, "trace too long");
        end

        prev_ns = 0;
        for (int i = 0; i < sched.size(); i++) begin
            @(posedge clk);
            #1;
            rst              = sched[i].rst;
            start_i          = sched[i].start;
            stop_req_i       = sched[i].stop;
            eval_done_i      = sched[i].done;
            eval_fitness_i   = 16'(sched[i].ef);
            sort_finished_i  = sched[i].sortf;
            breed_finished_i = sched[i].breedf;
            @(negedge clk);
            act_ns[i]   = int'(network_state_o);
            act_an[i]   = int'(active_network_o);
            act_fit[i]  = int'(fitness_o);
            act_gen[i]  = int'(generation_o);
            act_best[i] = int'(best_fitness_o);
            act_to[i]   = int'(timeout_seen_o);
            act_busy[i] = int'(busy_o);
            chk("networkState",  i, act_ns[i],   sched[i].ns);
            chk("activeNetwork", i, act_an[i],   sched[i].an);
            chk("fitness",       i, act_fit[i],  sched[i].fit);
            chk("generation",    i, act_gen[i],  sched[i].gen);
            chk("bestFitness",   i, act_best[i], sched[i].best);
            chk("timeoutSeen",   i, act_to[i],   sched[i].to);
            chk("busy",          i, act_busy[i], sched[i].busy);
            bad_turn = (prev_ns != 0 && act_ns[i] != 0 && act_ns[i] != prev_ns) ? 1 : 0;
            chk("turnaround", i, bad_turn, 0);
            if (prev_ns == 1 && act_ns[i] == 0)
                $display("cycle %0d: load network %0d fitness %0d gen %0d", i, act_an[i], act_fit[i], act_gen[i]);
            prev_ns = act_ns[i];
        end

        // Hand-computed anchors for the trace itself.
        chk("g1_best_at_gen_end",  g1 + 94, act_best[g1 + 94], 150);
        chk("g1_gen_at_gen_end",   g1 + 94, act_gen[g1 + 94],  0);
        chk("g2_first_eval_ns",    g1 + 95, act_ns[g1 + 95],   1);
        chk("g2_first_eval_gen",   g1 + 95, act_gen[g1 + 95],  1);
        chk("g2_first_eval_net",   g1 + 95, act_an[g1 + 95],   0);
        chk("net2_last_eval_ns",   e2 + 7,  act_ns[e2 + 7],    1);
        chk("net2_load_ns",        e2 + 8,  act_ns[e2 + 8],    0);
        chk("net2_load_fitness",   e2 + 8,  act_fit[e2 + 8],   27);
        chk("net2_load_timeout",   e2 + 8,  act_to[e2 + 8],    0);
        chk("net5_last_eval_ns",   e5 + 7,  act_ns[e5 + 7],    1);
        chk("net5_load_ns",        e5 + 8,  act_ns[e5 + 8],    0);
        chk("net5_load_net",       e5 + 8,  act_an[e5 + 8],    5);
        chk("net5_load_fitness",   e5 + 8,  act_fit[e5 + 8],   0);
        chk("net5_load_timeout",   e5 + 8,  act_to[e5 + 8],    1);
        chk("maxgen_idle_busy",    ia,      act_busy[ia],      0);
        chk("maxgen_idle_gen",     ia,      act_gen[ia],       3);
        chk("stop_idle_busy",      ib,      act_busy[ib],      0);
        chk("stop_idle_gen",       ib,      act_gen[ib],       1);
        chk("pre_reset_sort_ns",   rc - 1,  act_ns[rc - 1],    2);
        chk("reset_ns",            rc,      act_ns[rc],        0);
        chk("reset_busy",          rc,      act_busy[rc],      0);
        chk("reset_best",          rc,      act_best[rc],      0);
        chk("reset_net",           rc,      act_an[rc],        0);
        chk("fresh_run_net",       gd,      act_an[gd],        0);
        chk("fresh_run_ns",        gd,      act_ns[gd],        1);
        chk("min_gen_end_ns",      gd + 36, act_ns[gd + 36],   0);
        chk("min_gen_next_eval",   gd + 37, act_ns[gd + 37],   1);
        chk("min_gen_next_gen",    gd + 37, act_gen[gd + 37],  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
